// File: rtl/himax_roi_scheduler.sv
// himax_roi_scheduler
// Frame-level controller for the Himax video downscale/readout path. Steps through a rotation
// of quadrant/centre windows (one per captured frame), inserts full-frame captures on request,
// arms the video process block and hands every completed capture to the ML engine.
//
// Ports:
//   clk, resetn   - system clock, asynchronous active-low reset
//   i_enable      - run the rotation while high
//   i_cam_vsync   - raw sensor vsync, low during vertical blanking (asynchronous)
//   i_full_req    - pulse: request one full-frame capture (window 5)
//   i_rd_done     - video process has finished writing the armed frame (rising edge used)
//   i_ml_done     - pulse: ML engine finished with the last capture
//   o_frame_sel   - window select to the video process (0..4, 5 = full frame)
//   o_rd_rdy      - arm request to the video process
//   o_ml_start    - pulse: capture ready for ML
//   o_roi_tag     - window of the capture announced by o_ml_start
//   o_busy        - controller is not idle
//   o_err         - sticky capture-timeout flag
//   o_frame_cnt   - number of completed captures (wrapping)
module himax_roi_scheduler #(
    parameter logic [4:0]  ROI_MASK       = 5'b11111,
    parameter int unsigned TIMEOUT_FRAMES = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_enable,
    input  logic        i_cam_vsync,
    input  logic        i_full_req,
    input  logic        i_rd_done,
    input  logic        i_ml_done,
    output logic [2:0]  o_frame_sel,
    output logic        o_rd_rdy,
    output logic        o_ml_start,
    output logic [2:0]  o_roi_tag,
    output logic        o_busy,
    output logic        o_err,
    output logic [15:0] o_frame_cnt
);

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StMl} state_e;

    localparam logic [2:0] SelFull    = 3'd5;
    localparam logic [3:0] TimeoutLim = TIMEOUT_FRAMES[3:0];

    state_e      state_q, state_d;
    logic        vs_s1_q, vs_s2_q, vblank_q, vb_rise_q, rd_done_q;
    logic        vblank, rd_edge, full_pend;
    logic [2:0]  sel_q, sel_d, tag_q, tag_d, idx_q, idx_d, next_idx, cand;
    logic [3:0]  sum;
    logic        rdy_q, rdy_d, start_q, start_d, err_q, err_d, full_q, full_d;
    logic [3:0]  to_q, to_d;
    logic [15:0] cnt_q, cnt_d;

    assign vblank  = ~vs_s2_q;
    assign rd_edge = i_rd_done & ~rd_done_q;

    // Next window after idx_q: scan idx+1 .. idx+5 (mod 5); descending loop so the nearest wins.
    // The idx+5 step lands on idx itself, which reselects a lone window.
    always_comb begin
        next_idx = SelFull;
        sum      = '0;
        cand     = '0;
        for (int k = 5; k >= 1; k--) begin
            sum  = {1'b0, idx_q} + 4'(k);
            cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (ROI_MASK[cand]) begin
                next_idx = cand;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // Sync chain resets to "not blanking" so release never fakes a vblank edge.
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vblank_q  <= 1'b0;
            vb_rise_q <= 1'b0;
            rd_done_q <= 1'b0;
            state_q   <= StIdle;
            sel_q     <= '0;
            tag_q     <= '0;
            idx_q     <= 3'd4;
            rdy_q     <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            full_q    <= 1'b0;
            to_q      <= '0;
            cnt_q     <= '0;
        end else begin
            vs_s1_q   <= i_cam_vsync;
            vs_s2_q   <= vs_s1_q;
            vblank_q  <= vblank;
            vb_rise_q <= vblank & ~vblank_q;
            rd_done_q <= i_rd_done;
            state_q   <= state_d;
            sel_q     <= sel_d;
            tag_q     <= tag_d;
            idx_q     <= idx_d;
            rdy_q     <= rdy_d;
            start_q   <= start_d;
            err_q     <= err_d;
            full_q    <= full_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        rdy_d     = rdy_q;
        start_d   = 1'b0;
        err_d     = err_q;
        to_d      = to_q;
        cnt_d     = cnt_q;
        // A request arriving in the consuming cycle still counts.
        full_pend = full_q | i_full_req;
        full_d    = full_pend;
        case (state_q)
            StIdle: begin
                if (i_enable) state_d = StArm;
            end
            StArm: begin
                if (!i_enable) begin
                    state_d = StIdle;
                end else if (vb_rise_q) begin
                    sel_d   = full_pend ? SelFull : next_idx;
                    rdy_d   = 1'b1;
                    to_d    = '0;
                    full_d  = 1'b0;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Done has priority over a coincident vblank edge.
                if (rd_edge) begin
                    rdy_d   = 1'b0;
                    start_d = 1'b1;
                    tag_d   = sel_q;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = StMl;
                end else if (vb_rise_q && (to_q + 4'd1 >= TimeoutLim)) begin
                    err_d   = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = StArm;
                end else if (!i_enable) begin
                    rdy_d   = 1'b0;
                    state_d = StIdle;
                end else if (vb_rise_q) begin
                    to_d = to_q + 4'd1;
                end
            end
            StMl: begin
                if (i_ml_done) begin
                    // Full-frame captures do not advance the rotation.
                    if (tag_q != SelFull) idx_d = tag_q;
                    state_d = i_enable ? StArm : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        o_frame_sel = sel_q;
        o_rd_rdy    = rdy_q;
        o_ml_start  = start_q;
        o_roi_tag   = tag_q;
        o_busy      = (state_q != StIdle);
        o_err       = err_q;
        o_frame_cnt = cnt_q;
    end

endmodule

// File: tb/tb_himax_roi_scheduler.sv
`timescale 1ns/1ps
module tb_himax_roi_scheduler;

    localparam logic [4:0] MASK = 5'b10101;
    localparam int         TO   = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en = 1'b0, vsync = 1'b1, full_req = 1'b0, rd_done = 1'b0, ml_done = 1'b0;

    logic [2:0]  sel, tag, sel0, tag0;
    logic        rdy, start, busy, err, rdy0, start0, busy0, err0;
    logic [15:0] cnt, cnt0;

    himax_roi_scheduler #(.ROI_MASK(MASK), .TIMEOUT_FRAMES(TO)) dut (
        .clk(clk), .resetn(resetn), .i_enable(en), .i_cam_vsync(vsync),
        .i_full_req(full_req), .i_rd_done(rd_done), .i_ml_done(ml_done),
        .o_frame_sel(sel), .o_rd_rdy(rdy), .o_ml_start(start), .o_roi_tag(tag),
        .o_busy(busy), .o_err(err), .o_frame_cnt(cnt)
    );

    // Second instance with an empty mask: every capture must be full frame.
    himax_roi_scheduler #(.ROI_MASK(5'b00000), .TIMEOUT_FRAMES(TO)) dut0 (
        .clk(clk), .resetn(resetn), .i_enable(en), .i_cam_vsync(vsync),
        .i_full_req(full_req), .i_rd_done(rd_done), .i_ml_done(ml_done),
        .o_frame_sel(sel0), .o_rd_rdy(rdy0), .o_ml_start(start0), .o_roi_tag(tag0),
        .o_busy(busy0), .o_err(err0), .o_frame_cnt(cnt0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Window choice: the lowest enabled window above the last one, else the lowest overall.
    function automatic int pick_window(input int last, input logic [4:0] mask);
        int first;
        first = 5;
        for (int w = 4; w >= 0; w--) if (mask[w]) first = w;
        for (int w = last + 1; w < 5; w++) if (mask[w]) return w;
        return first;
    endfunction

    int          m_mode;      // 0 idle, 1 arm, 2 capture, 3 ml
    logic [3:0]  vs_hist;     // [i] = vsync sampled i+1 edges ago
    bit          rd_prev;
    int          m_last, m_to, m_starts = 0;
    bit          m_full;
    logic [2:0]  e_sel, e_tag;
    bit          e_rdy, e_start, e_err;
    logic [15:0] e_cnt;

    always @(posedge clk) begin
        bit vbr, rde, full_now;
        if (!resetn) begin
            m_mode = 0; vs_hist = 4'b1111; rd_prev = 0; m_last = 4; m_to = 0; m_full = 0;
            e_sel = 0; e_tag = 0; e_rdy = 0; e_start = 0; e_err = 0; e_cnt = 0;
        end else begin
            // Blanking seen through two sync stages plus one edge register.
            vbr      = !vs_hist[2] && vs_hist[3];
            rde      = rd_done && !rd_prev;
            full_now = m_full || full_req;
            e_start  = 0;
            case (m_mode)
                0: if (en) m_mode = 1;
                1: begin
                    if (!en) m_mode = 0;
                    else if (vbr) begin
                        e_sel    = full_now ? 3'd5 : 3'(pick_window(m_last, MASK));
                        e_rdy    = 1;
                        m_to     = 0;
                        full_now = 0;
                        m_mode   = 2;
                    end
                end
                2: begin
                    if (rde) begin
                        e_rdy = 0; e_start = 1; e_tag = e_sel; e_cnt = e_cnt + 16'd1;
                        m_starts++;
                        m_mode = 3;
                    end else if (vbr && m_to + 1 >= TO) begin
                        e_err = 1; e_rdy = 0; m_mode = 1;
                    end else if (!en) begin
                        e_rdy = 0; m_mode = 0;
                    end else if (vbr) begin
                        m_to++;
                    end
                end
                default: begin
                    if (ml_done) begin
                        if (e_tag != 3'd5) m_last = int'(e_tag);
                        m_mode = en ? 1 : 0;
                    end
                end
            endcase
            m_full  = full_now;
            vs_hist = {vs_hist[2:0], vsync};
            rd_prev = rd_done;
        end
    end

    // ---------------- per-cycle compare ----------------
    int tags[$];
    int n_start0 = 0;

    always @(negedge clk) begin
        if (resetn) begin
            chk("frame_sel", 16'(sel), 16'(e_sel));
            chk("rd_rdy", 16'(rdy), 16'(e_rdy));
            chk("ml_start", 16'(start), 16'(e_start));
            chk("roi_tag", 16'(tag), 16'(e_tag));
            chk("busy", 16'(busy), 16'(m_mode != 0));
            chk("err", 16'(err), 16'(e_err));
            chk("frame_cnt", cnt, e_cnt);
            if (start) tags.push_back(int'(tag));
            if (rdy0) chk("mask0_sel", 16'(sel0), 16'd5);
            if (start0) begin
                chk("mask0_tag", 16'(tag0), 16'd5);
                n_start0++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Four clocks of blanking; returns just after the edge that arms a waiting block.
    task automatic vblank();
        vsync = 1'b0;
        tick(4);
        vsync = 1'b1;
    endtask

    task automatic frame(input bit full_in_ml);
        vblank();
        tick(4);
        rd_done = 1'b1; tick(2); rd_done = 1'b0;
        tick(2);
        if (full_in_ml) begin
            full_req = 1'b1; tick(1); full_req = 1'b0;
        end
        tick(2);
        ml_done = 1'b1; tick(1); ml_done = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int exp_tags[14] = '{0, 2, 4, 0, 2, 4, 0, 2, 5, 4, 0, 2, 4, 0};

    initial begin
        tick(3);
        chk("reset_sel", 16'(sel), 16'd0);
        chk("reset_rdy", 16'(rdy), 16'd0);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_cnt", cnt, 16'd0);
        resetn = 1'b1;
        tick(2);
        en = 1'b1;
        tick(2);

        // Latency: vsync fall -> rd_rdy at +4, rd_done rise -> ml_start at +1.
        vsync = 1'b0;
        tick(3);
        chk("lat_rdy_early", 16'(rdy), 16'd0);
        tick(1);
        chk("lat_rdy_4clk", 16'(rdy), 16'd1);
        chk("lat_sel_first", 16'(sel), 16'd0);
        vsync = 1'b1;
        tick(4);
        rd_done = 1'b1;
        tick(1);
        chk("lat_start_1clk", 16'(start), 16'd1);
        chk("lat_rdy_drop", 16'(rdy), 16'd0);
        tick(1);
        chk("lat_start_pulse", 16'(start), 16'd0);
        rd_done = 1'b0;
        tick(3);
        ml_done = 1'b1; tick(1); ml_done = 1'b0;
        tick(2);

        // Rotation 2,4,0,2,4.
        for (int i = 0; i < 5; i++) frame(1'b0);
        chk("cnt_after_6", cnt, 16'd6);

        // Full request during ML of window 2.
        frame(1'b0);
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);
        chk("cnt_after_10", cnt, 16'd10);
        chk("model_cnt_10", e_cnt, 16'd10);

        // Third counted vblank coincides with rd_done: done wins, no error.
        vblank(); tick(4);
        vblank(); tick(4);
        vblank(); tick(4);
        vsync = 1'b0;
        tick(3);
        rd_done = 1'b1;
        tick(1);
        vsync = 1'b1;
        chk("simul_start", 16'(start), 16'd1);
        chk("simul_no_err", 16'(err), 16'd0);
        tick(2); rd_done = 1'b0; tick(2);
        ml_done = 1'b1; tick(1); ml_done = 1'b0;
        tick(2);

        // Timeout: arming vblank plus three counted ones.
        vblank(); tick(4);
        chk("to_armed_sel", 16'(sel), 16'd2);
        vblank(); tick(4);
        vblank(); tick(4);
        chk("to_no_err_yet", 16'(err), 16'd0);
        vblank();
        chk("to_err", 16'(err), 16'd1);
        chk("to_rdy_drop", 16'(rdy), 16'd0);
        tick(4);
        vblank();
        chk("to_retry_rdy", 16'(rdy), 16'd1);
        chk("to_retry_sel", 16'(sel), 16'd2);
        tick(4);
        rd_done = 1'b1; tick(2); rd_done = 1'b0; tick(2);
        ml_done = 1'b1; tick(1); ml_done = 1'b0;
        tick(2);

        // Enable dropped in CAPTURE, then in ML.
        vblank();
        tick(3);
        en = 1'b0;
        tick(1);
        chk("dis_cap_rdy", 16'(rdy), 16'd0);
        chk("dis_cap_busy", 16'(busy), 16'd0);
        tick(2);
        en = 1'b1;
        tick(2);
        vblank();
        chk("reen_sel", 16'(sel), 16'd4);
        tick(4);
        rd_done = 1'b1; tick(2); rd_done = 1'b0; tick(2);
        en = 1'b0;
        tick(3);
        chk("dis_ml_busy", 16'(busy), 16'd1);
        ml_done = 1'b1; tick(1); ml_done = 1'b0;
        chk("dis_ml_idle", 16'(busy), 16'd0);
        tick(2);

        // Asynchronous reset mid-CAPTURE.
        en = 1'b1;
        tick(2);
        vblank();
        tick(2);
        #2 resetn = 1'b0;
        #1;
        chk("rst_rdy", 16'(rdy), 16'd0);
        chk("rst_sel", 16'(sel), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_tag", 16'(tag), 16'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);
        frame(1'b0);
        chk("post_rst_cnt", cnt, 16'd1);

        // Captured window sequence and empty-mask instance activity.
        chk("tag_count", 16'(tags.size()), 16'd14);
        for (int i = 0; i < 14; i++) begin
            if (i < tags.size()) chk("tag_seq", 16'(tags[i]), 16'(exp_tags[i]));
        end
        chk("mask0_starts", 16'(n_start0), 16'(m_starts));
        chk("model_starts", 16'(m_starts), 16'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
